// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: operand stack and pop-pop-compute-push sequencer for the
// RPN calculator. Accepts entry-stage commands over a valid/ready handshake and
// presents top-of-stack, depth and sticky error status to the display logic.
// Optional divider: define RPN_STACK_DIV_EN to build opcode 110 (unsigned DIV);
// without it opcode 110 is rejected as an illegal op.
module rpn_stack_engine #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [DATA_W-1:0]          cmd_data,
    output logic [DATA_W-1:0]          tos,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    typedef enum logic [2:0] {
        OP_PUSH  = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_MUL   = 3'b011,
        OP_DUP   = 3'b100,
        OP_DROP  = 3'b101,
        OP_DIV   = 3'b110,
        OP_CLEAR = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_UNDER   = 2'b01,
        ERR_OVER    = 2'b10,
        ERR_ILLEGAL = 2'b11
    } err_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    op_t               op_in;
    op_t               op_q;
    logic [DW-1:0]     sp;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] r_q;
    logic              div0_q;
    err_t              err_q;

    logic              accept;
    logic              sp_empty;
    logic              sp_full;
    logic              sp_ge2;
    logic              acc_err;
    err_t              acc_code;
    logic [DATA_W-1:0] rd_top;
    logic [DATA_W-1:0] rd_next;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign op_in    = op_t'(cmd_op);
    assign accept   = (state == IDLE) && cmd_valid && cmd_ready;
    assign sp_empty = (sp == '0);
    assign sp_full  = (sp == DW'(DEPTH));
    assign sp_ge2   = (sp >= DW'(2));
    assign rd_top   = mem[AW'(sp - DW'(1))];
    assign rd_next  = mem[AW'(sp - DW'(2))];

    assign depth    = sp;
    assign empty    = sp_empty;
    assign full     = sp_full;
    assign err_code = err_q;

    // Classify the command being accepted: any error found here blocks it entirely
    always_comb begin
        acc_err  = 1'b0;
        acc_code = ERR_NONE;
        if (accept) begin
            case (op_in)
                OP_PUSH: begin
                    if (sp_full) begin
                        acc_err  = 1'b1;
                        acc_code = ERR_OVER;
                    end
                end
                OP_DUP: begin
                    if (sp_empty) begin
                        acc_err  = 1'b1;
                        acc_code = ERR_UNDER;
                    end else if (sp_full) begin
                        acc_err  = 1'b1;
                        acc_code = ERR_OVER;
                    end
                end
                OP_DROP: begin
                    if (sp_empty) begin
                        acc_err  = 1'b1;
                        acc_code = ERR_UNDER;
                    end
                end
                OP_ADD, OP_SUB, OP_MUL: begin
                    if (!sp_ge2) begin
                        acc_err  = 1'b1;
                        acc_code = ERR_UNDER;
                    end
                end
                OP_DIV: begin
`ifdef RPN_STACK_DIV_EN
                    if (!sp_ge2) begin
                        acc_err  = 1'b1;
                        acc_code = ERR_UNDER;
                    end
`else
                    acc_err  = 1'b1;
                    acc_code = ERR_ILLEGAL;
`endif
                end
                default: ;
            endcase
        end
    end

    // Stack RAM write port: PUSH/DUP at acceptance, binary result in WB
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (accept && !acc_err && (op_in == OP_PUSH)) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(sp);
            mem_wdata = cmd_data;
        end else if (accept && !acc_err && (op_in == OP_DUP)) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(sp);
            mem_wdata = tos;
        end else if ((state == WB) && !div0_q) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(sp - DW'(2));
            mem_wdata = r_q;
        end
    end

    // Stack RAM storage; contents are don't-care after reset, and the write is
    // gated so an asynchronous reset cannot land a partial result
    always_ff @(posedge CLOCK_50) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Sequencer FSM with stack pointer, top-of-stack and sticky error registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sp        <= '0;
            tos       <= '0;
            err       <= 1'b0;
            err_q     <= ERR_NONE;
            cmd_ready <= 1'b1;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            div0_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_in;
                        div0_q <= 1'b0;
                        if (acc_err) begin
                            if (!err) begin
                                err   <= 1'b1;
                                err_q <= acc_code;
                            end
                        end else begin
                            case (op_in)
                                OP_PUSH: begin
                                    sp  <= sp + DW'(1);
                                    tos <= cmd_data;
                                end
                                OP_DUP: begin
                                    sp <= sp + DW'(1);
                                end
                                OP_DROP: begin
                                    sp  <= sp - DW'(1);
                                    tos <= sp_ge2 ? rd_next : '0;
                                end
                                OP_CLEAR: begin
                                    sp    <= '0;
                                    tos   <= '0;
                                    err   <= 1'b0;
                                    err_q <= ERR_NONE;
                                end
                                default: begin
                                    state     <= FETCH;
                                    cmd_ready <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                FETCH: begin
                    b_q   <= rd_top;
                    a_q   <= rd_next;
                    state <= EXEC;
                end
                EXEC: begin
                    case (op_q)
                        OP_ADD: r_q <= a_q + b_q;
                        OP_SUB: r_q <= a_q - b_q;
                        OP_MUL: r_q <= a_q * b_q;
`ifdef RPN_STACK_DIV_EN
                        OP_DIV: begin
                            if (b_q == '0) begin
                                div0_q <= 1'b1;
                                if (!err) begin
                                    err   <= 1'b1;
                                    err_q <= ERR_ILLEGAL;
                                end
                            end else begin
                                r_q <= a_q / b_q;
                            end
                        end
`endif
                        default: r_q <= '0;
                    endcase
                    state <= WB;
                end
                WB: begin
                    if (!div0_q) begin
                        sp  <= sp - DW'(1);
                        tos <= r_q;
                    end
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/rpn_stack_engine.md
Name: rpn_stack_engine

Overview:
- Operand stack plus arithmetic sequencer for the RPN calculator.
- Sits directly downstream of the key/switch entry FSM. It consumes that FSM's push and operator commands over a valid/ready handshake.
- Holds the operand stack and executes pop-pop-compute-push sequences.
- Presents top-of-stack, depth and error status to the LEDR/HEX display logic.

Parameters:
- DATA_W, 8, operand width in bits.
- DEPTH, 8, maximum number of stack entries (>= 2).

Ports:
- CLOCK_50  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  entry stage presents a command.
- cmd_ready  output  1  engine can accept a command this cycle.
- cmd_op  input  3  opcode: 000 PUSH, 001 ADD, 010 SUB, 011 MUL, 100 DUP, 101 DROP, 110 DIV, 111 CLEAR.
- cmd_data  input  DATA_W  operand for PUSH; ignored otherwise.
- tos  output  DATA_W  registered top-of-stack value; 0 when empty.
- depth  output  $clog2(DEPTH+1)  number of valid entries.
- empty  output  1  depth == 0.
- full  output  1  depth == DEPTH.
- err  output  1  sticky error flag.
- err_code  output  2  first error since last clear: 00 none, 01 underflow, 10 overflow, 11 illegal op / divide-by-zero.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state IDLE, sp=0, tos=0, depth=0;
  - empty=1, full=0, err=0, err_code=00, cmd_ready=1.
  - Stack RAM contents are don't-care.
  - Reset mid-sequence abandons the operation; no partial write is visible.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - cmd_ready = 1 only in state IDLE.
  - cmd_op and cmd_data are sampled only at acceptance.
- States: IDLE, FETCH, EXEC, WB.
- Single-cycle commands (stay in IDLE; result visible after the accept edge; ready again next cycle):
  - PUSH: mem[sp]=cmd_data, sp+1, tos=cmd_data.
  - DUP: mem[sp]=tos, sp+1.
  - DROP: sp-1; tos becomes the new top, or 0 if empty.
  - CLEAR: sp=0, tos=0, err=0, err_code=00.
- Binary ops (ADD, SUB, MUL, DIV):
  - Accept at edge k: IDLE->FETCH.
  - FETCH: latch B=mem[sp-1] (top) and A=mem[sp-2]. FETCH->EXEC.
  - EXEC: compute R. EXEC->WB.
  - WB: mem[sp-2]=R, sp-1, tos=R. WB->IDLE.
  - tos/depth updated by edge k+3; cmd_ready low for 3 cycles and high again in the cycle after edge k+3.
- Arithmetic: unsigned, modulo 2^DATA_W.
  - ADD = A+B; SUB = A-B (wraps, e.g. 3-5 = 254 for DATA_W=8).
  - MUL = low DATA_W bits of A*B.
  - DIV = floor(A/B).
- Error checks (made at acceptance in IDLE unless noted):
  - PUSH or DUP when full: overflow (10).
  - DROP or DUP when empty: underflow (01).
  - Binary op with depth < 2: underflow (01). No state transition; stack, tos and depth unchanged.
  - DIV with B==0: detected in EXEC; WB performs no write, sp unchanged, code 11; still returns to IDLE at k+3.
- Error flag behaviour:
  - err is sticky and err_code keeps the first error.
  - Later errors do not overwrite it; only CLEAR or reset clears it.
  - Commands continue to execute normally while err=1.
- Boundaries:
  - PUSH at depth DEPTH-1 succeeds and sets full.
  - Binary op at depth exactly 2 succeeds, leaving depth 1.
  - sp never wraps.
  - cmd_valid held high across back-to-back commands is legal; each is accepted once per cmd_ready window.

Optional Feature:
- Macro RPN_STACK_DIV_EN.
- Defined: opcode 110 performs unsigned divide as specified, including the divide-by-zero error.
- Undefined: no divider hardware is built. Opcode 110 is rejected at acceptance with err_code 11, no state transition, and the stack unchanged.

Test Plan:
- Reset, then PUSH 7, PUSH 5, SUB -> tos=2, depth=1; cmd_ready low exactly 3 cycles after the SUB accept.
- PUSH 3, PUSH 5, SUB -> tos=254; then PUSH 200, PUSH 100, ADD -> tos=44 (wrap), depth=2.
- Push DEPTH values, then PUSH 9 -> full=1, err=1, err_code=10, tos unchanged. Then DROP -> depth=DEPTH-1, err_code still 10. Then CLEAR -> depth=0, err=0, err_code=00.
- From empty: ADD -> err_code=01, cmd_ready never deasserts. Then PUSH 4, DUP, MUL -> tos=16, depth=1, err_code still 01.
- With RPN_STACK_DIV_EN: PUSH 20, PUSH 6, DIV -> tos=3. Then PUSH 0, DIV -> err_code=11, depth=2, tos=0. Without the macro, PUSH 20, PUSH 6, DIV -> err_code=11, depth=2, tos=6.
- Assert reset during EXEC of an ADD (PUSH 1, PUSH 2 first) -> immediately depth=0, tos=0, cmd_ready=1, err=0.
